// File: rtl/commit_arbiter.sv
// Round-robin merge of per-unit commit streams into one commit stream. Multi-beat packets
// are never interleaved, the output is buffered two deep, and retirement counters are kept.
module commit_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 128,
    parameter int NUM_LANES  = 4,
    parameter int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]     data_in,
    input  logic [NUM_INPUTS*NUM_LANES-1:0] tmask_in,
    input  logic [NUM_INPUTS-1:0]           sop_in,
    input  logic [NUM_INPUTS-1:0]           eop_in,
    output logic [NUM_INPUTS-1:0]           ready_out,
    output logic                            valid_out,
    output logic [DATAW-1:0]                data_out,
    output logic [NUM_LANES-1:0]            tmask_out,
    output logic                            sop_out,
    output logic                            eop_out,
    output logic [SELW-1:0]                 sel_out,
    input  logic                            ready_in,
    output logic [63:0]                     retired_instrs,
    output logic [63:0]                     retired_threads
);

    function automatic logic [63:0] popcount(input logic [NUM_LANES-1:0] m);
        logic [63:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + 64'(m[i]);
        end
        return n;
    endfunction

    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
        if (int'(i) == NUM_INPUTS - 1) begin
            return '0;
        end
        return i + SELW'(1);
    endfunction

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             lock_q, lock_d;
    logic [SELW-1:0]  lk_q, lk_d;
    logic [SELW-1:0]  rr_q, rr_d;
    logic [63:0]      instrs_q, instrs_d;
    logic [63:0]      threads_q, threads_d;

    logic [DATAW-1:0]     data_mem_q  [2];
    logic [NUM_LANES-1:0] tmask_mem_q [2];
    logic                 sop_mem_q   [2];
    logic                 eop_mem_q   [2];
    logic [SELW-1:0]      sel_mem_q   [2];

    logic                  space;
    logic [NUM_INPUTS-1:0] grant;
    logic [SELW-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  accept;
    logic                  pop;
    logic [DATAW-1:0]      acc_data;
    logic [NUM_LANES-1:0]  acc_tmask;
    logic                  acc_sop;
    logic                  acc_eop;

    // Space comes from the registered count only, so ready_in never reaches ready_out.
    assign space = (count_q != 2'd2);

    // While locked, only the packet owner is eligible; otherwise the first valid source
    // at or after rr wins. Scanning downward lets the smallest offset overwrite the rest.
    always_comb begin
        int idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (lock_q) begin
            gnt_idx = lk_q;
            gnt_any = 1'b1;
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_INPUTS) begin
                    idx = idx - NUM_INPUTS;
                end
                if (valid_in[idx]) begin
                    gnt_idx = SELW'(idx);
                    gnt_any = 1'b1;
                end
            end
        end
        grant[gnt_idx] = gnt_any;
    end

    assign ready_out = (space && !reset) ? grant : '0;
    assign accept    = |(valid_in & ready_out);
    assign acc_data  = data_in[int'(gnt_idx) * DATAW +: DATAW];
    assign acc_tmask = tmask_in[int'(gnt_idx) * NUM_LANES +: NUM_LANES];
    assign acc_sop   = sop_in[gnt_idx];
    assign acc_eop   = eop_in[gnt_idx];

    assign valid_out       = (count_q != 2'd0);
    assign data_out        = data_mem_q[rd_ptr_q];
    assign tmask_out       = tmask_mem_q[rd_ptr_q];
    assign sop_out         = sop_mem_q[rd_ptr_q];
    assign eop_out         = eop_mem_q[rd_ptr_q];
    assign sel_out         = sel_mem_q[rd_ptr_q];
    assign pop             = valid_out && ready_in;
    assign retired_instrs  = instrs_q;
    assign retired_threads = threads_q;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lock_d    = lock_q;
        lk_d      = lk_q;
        rr_d      = rr_q;
        instrs_d  = instrs_q;
        threads_d = threads_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
            if (acc_eop) begin
                lock_d = 1'b0;
                rr_d   = next_idx(gnt_idx);
            end else begin
                lock_d = 1'b1;
                lk_d   = gnt_idx;
            end
        end
        if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            threads_d = threads_q + popcount(tmask_out);
            if (eop_out) begin
                instrs_d = instrs_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            lock_q    <= 1'b0;
            lk_q      <= '0;
            rr_q      <= '0;
            instrs_q  <= '0;
            threads_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lock_q    <= lock_d;
            lk_q      <= lk_d;
            rr_q      <= rr_d;
            instrs_q  <= instrs_d;
            threads_q <= threads_d;
        end
    end

    // Payload storage carries no reset; valid_out masks stale entries.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem_q[wr_ptr_q]  <= acc_data;
            tmask_mem_q[wr_ptr_q] <= acc_tmask;
            sop_mem_q[wr_ptr_q]   <= acc_sop;
            eop_mem_q[wr_ptr_q]   <= acc_eop;
            sel_mem_q[wr_ptr_q]   <= gnt_idx;
        end
    end

    // A source that is not mid-packet must open with sop; such beats pass through unchanged.
    a_sop_when_unlocked: assert property (@(posedge clk) disable iff (reset)
        (accept && !lock_q) |-> acc_sop);

endmodule

// File: tb/tb_commit_arbiter.sv
// Randomized and directed bench for commit_arbiter, checked against a queue-based reference model.
module tb_commit_arbiter;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int NL = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    valid_in;
    logic [N*DW-1:0] data_in;
    logic [N*NL-1:0] tmask_in;
    logic [N-1:0]    sop_in;
    logic [N-1:0]    eop_in;
    logic [N-1:0]    ready_out;
    logic            valid_out;
    logic [DW-1:0]   data_out;
    logic [NL-1:0]   tmask_out;
    logic            sop_out;
    logic            eop_out;
    logic [SW-1:0]   sel_out;
    logic            ready_in;
    logic [63:0]     retired_instrs;
    logic [63:0]     retired_threads;

    always #5 clk = ~clk;

    commit_arbiter #(.NUM_INPUTS(N), .DATAW(DW), .NUM_LANES(NL), .SELW(SW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .tmask_in(tmask_in), .sop_in(sop_in), .eop_in(eop_in), .ready_out(ready_out),
        .valid_out(valid_out), .data_out(data_out), .tmask_out(tmask_out),
        .sop_out(sop_out), .eop_out(eop_out), .sel_out(sel_out), .ready_in(ready_in),
        .retired_instrs(retired_instrs), .retired_threads(retired_threads)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [NL-1:0] m;
        logic          sop;
        logic          eop;
        int            sel;
    } beat_t;

    beat_t       src_q [N][$];
    beat_t       fifo_m[$];
    logic        lock_m;
    int          lk_m;
    int          rr_m;
    logic [63:0] instrs_m;
    logic [63:0] threads_m;
    int          out_sel_log[$];
    int          acc_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rand_gate = 0;
    bit          rdy_rand  = 0;
    bit          rdy_fix   = 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Ready predicted straight from the arbitration rules and the model buffer occupancy.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (fifo_m.size() >= 2) return r;
        if (lock_m) begin
            r[lk_m] = 1'b1;
            return r;
        end
        for (int k = 0; k < N; k++) begin
            if (valid_in[(rr_m + k) % N]) begin
                r[(rr_m + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic push_pkt(input int s, input int len, input logic [NL-1:0] m0);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.d   = {$urandom, $urandom, $urandom, $urandom};
            x.m   = (b == 0) ? m0 : NL'($urandom);
            x.sop = (b == 0);
            x.eop = (b == len - 1);
            x.sel = s;
            src_q[s].push_back(x);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && (!rand_gate || $urandom_range(0, 3) != 0)) begin
                valid_in[i]           = 1'b1;
                data_in[i*DW +: DW]   = src_q[i][0].d;
                tmask_in[i*NL +: NL]  = src_q[i][0].m;
                sop_in[i]             = src_q[i][0].sop;
                eop_in[i]             = src_q[i][0].eop;
            end else begin
                valid_in[i] = 1'b0;
                sop_in[i]   = 1'b0;
                eop_in[i]   = 1'b0;
            end
        end
        ready_in = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    endtask

    task automatic step();
        logic [N-1:0] er;
        int           a;
        bit           pop;
        beat_t        x;
        er = model_ready();
        chk("ready_out", 128'(ready_out), 128'(er));
        chk("valid_out", 128'(valid_out), 128'(fifo_m.size() > 0));
        if (fifo_m.size() > 0) begin
            chk("data_out", 128'(data_out), 128'(fifo_m[0].d));
            chk("tmask_out", 128'(tmask_out), 128'(fifo_m[0].m));
            chk("sop_out", 128'(sop_out), 128'(fifo_m[0].sop));
            chk("eop_out", 128'(eop_out), 128'(fifo_m[0].eop));
            chk("sel_out", 128'(sel_out), 128'(fifo_m[0].sel));
        end
        chk("retired_instrs", 128'(retired_instrs), 128'(instrs_m));
        chk("retired_threads", 128'(retired_threads), 128'(threads_m));
        a = -1;
        for (int i = 0; i < N; i++) if (valid_in[i] && er[i]) a = i;
        pop = (fifo_m.size() > 0) && ready_in;
        @(posedge clk);
        #1;
        if (pop) begin
            threads_m = threads_m + 64'($countones(fifo_m[0].m));
            if (fifo_m[0].eop) instrs_m = instrs_m + 64'd1;
            out_sel_log.push_back(fifo_m[0].sel);
            void'(fifo_m.pop_front());
        end
        if (a >= 0) begin
            x = src_q[a].pop_front();
            acc_cnt++;
            fifo_m.push_back(x);
            if (x.eop) begin
                lock_m = 1'b0;
                rr_m   = (a + 1) % N;
            end else begin
                lock_m = 1'b1;
                lk_m   = a;
            end
        end
        drive();
        #1;
    endtask

    function automatic bit busy();
        bit b;
        b = (fifo_m.size() > 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        chk("drain_done", 128'(busy()), 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        fifo_m.delete();
        out_sel_log.delete();
        lock_m = 1'b0; lk_m = 0; rr_m = 0; instrs_m = '0; threads_m = '0; acc_cnt = 0;
        valid_in = '1; sop_in = '1; eop_in = '1; ready_in = 1'b1;
        data_in = '0; tmask_in = '1;
        #1;
        chk("ready_in_reset", 128'(ready_out), 128'(0));
        @(posedge clk);
        #1;
        chk("valid_rst", 128'(valid_out), 128'(0));
        chk("instrs_rst", 128'(retired_instrs), 128'(0));
        chk("threads_rst", 128'(retired_threads), 128'(0));
        chk("lock_rst", 128'(dut.lock_q), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        valid_in = '0; data_in = '0; tmask_in = '0; sop_in = '0; eop_in = '0; ready_in = 1'b0;
        do_reset();

        // Single source, three single-beat packets.
        rdy_fix = 1'b1;
        push_pkt(0, 1, 4'hF); push_pkt(0, 1, 4'h3); push_pkt(0, 1, 4'h1);
        drive(); #1;
        drain(50);
        chk("t1_instrs", 128'(retired_instrs), 128'(3));
        chk("t1_threads", 128'(retired_threads), 128'(7));
        chk("t1_count", 128'(out_sel_log.size()), 128'(3));
        for (int k = 0; k < out_sel_log.size(); k++) chk("t1_sel", 128'(out_sel_log[k]), 128'(0));

        // All four sources contending with single-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) push_pkt(s, 1, NL'($urandom));
        drive(); #1;
        drain(60);
        chk("t2_count", 128'(out_sel_log.size()), 128'(8));
        for (int k = 0; k < out_sel_log.size(); k++) chk("t2_order", 128'(out_sel_log[k]), 128'(k % 4));

        // Locked 4-beat packet from source 1 with source 2 waiting.
        do_reset();
        push_pkt(1, 4, 4'h5); push_pkt(2, 1, 4'hA);
        drive(); #1;
        drain(60);
        chk("t3_count", 128'(out_sel_log.size()), 128'(5));
        for (int k = 0; k < out_sel_log.size(); k++)
            chk("t3_sel", 128'(out_sel_log[k]), 128'((k < 4) ? 1 : 2));
        chk("t3_rr", 128'(dut.rr_q), 128'(3));

        // Backpressure: only two beats enter while ready_in is low.
        do_reset();
        rdy_fix = 1'b0;
        for (int k = 0; k < 5; k++) push_pkt(0, 1, NL'($urandom));
        drive(); #1;
        acc_cnt = 0;
        repeat (5) step();
        chk("t4_acc", 128'(acc_cnt), 128'(2));
        chk("t4_rdy0", 128'(ready_out[0]), 128'(0));
        rdy_fix = 1'b1;
        drive(); #1;
        drain(60);
        chk("t4_count", 128'(out_sel_log.size()), 128'(5));
        chk("t4_acc_all", 128'(acc_cnt), 128'(5));

        // Reset in the middle of a 3-beat packet, then a fresh packet from source 3.
        do_reset();
        rdy_fix = 1'b0;
        push_pkt(1, 3, 4'h7);
        drive(); #1;
        step(); step();
        chk("t5_locked", 128'(dut.lock_q), 128'(1));
        do_reset();
        rdy_fix = 1'b1;
        push_pkt(3, 1, 4'h9);
        drive(); #1;
        chk("t5_grant3", 128'(ready_out), 128'(4'b1000));
        drain(20);
        chk("t5_instrs", 128'(retired_instrs), 128'(1));

        // Retired instruction counter wrap.
        do_reset();
        force dut.instrs_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instrs_q;
        #1;
        instrs_m = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("wrap_pre", 128'(retired_instrs), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        push_pkt(0, 1, 4'hF);
        drive(); #1;
        drain(20);
        chk("wrap", 128'(retired_instrs), 128'(0));
        chk("wrap_threads", 128'(retired_threads), 128'(4));

        // Random traffic: packet lengths 1..4, gated valids, random backpressure.
        do_reset();
        rand_gate = 1'b1;
        rdy_rand  = 1'b1;
        drive(); #1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                if (src_q[s].size() < 8) push_pkt(s, $urandom_range(1, 4), NL'($urandom));
            end
            step();
        end
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        drain(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_arbiter.md
Name: commit_arbiter

Overview:
- Merges the commit streams of NUM_INPUTS execution units (ALU, LSU, FPU, SFU, vector) into the single commit stream consumed by the commit/writeback stage.
- Arbitration is round-robin, and a multi-beat packet (sop..eop, one beat per lane group) is never interleaved with another source.
- Output goes through a 2-entry buffer, which cuts the ready path.
- The block also maintains retired-instruction and retired-thread counters for the CSR/perf unit.

Parameters:
- NUM_INPUTS, 4, number of upstream commit sources.
- DATAW, 128, width of the opaque commit payload (uuid, wid, PC, wb, rd, data, pid).
- NUM_LANES, 4, lanes per beat; width of tmask.
- SELW, $clog2(NUM_INPUTS) with a minimum of 1, width of the source index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  NUM_INPUTS  per-source beat valid.
- data_in  in  NUM_INPUTS*DATAW  per-source payload; source i occupies bits [i*DATAW +: DATAW].
- tmask_in  in  NUM_INPUTS*NUM_LANES  per-source thread mask.
- sop_in  in  NUM_INPUTS  first beat of packet.
- eop_in  in  NUM_INPUTS  last beat of packet.
- ready_out  out  NUM_INPUTS  per-source accept.
- valid_out  out  1  merged beat valid.
- data_out  out  DATAW  merged payload.
- tmask_out  out  NUM_LANES  merged thread mask.
- sop_out  out  1  merged start of packet.
- eop_out  out  1  merged end of packet.
- sel_out  out  SELW  source index of the current output beat.
- ready_in  in  1  downstream accept.
- retired_instrs  out  64  count of packets committed (eop beats accepted downstream).
- retired_threads  out  64  sum of popcount(tmask_out) over all accepted output beats.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Values while and after reset:
  - valid_out=0 and ready_out=0.
  - Buffer count=0, lock=0, rr pointer=0.
  - retired_instrs=0 and retired_threads=0.
  - data_out, tmask_out, sop_out, eop_out and sel_out are don't-care while valid_out=0.
- Buffer: 2-entry FIFO holding {data, tmask, sop, eop, sel}.
  - space = (count<2), computed from registered count only; no combinational path from ready_in to ready_out.
- Unlocked arbitration: grant goes to the first valid source at or after rr, scanning cyclically (rr, rr+1, …, wrapping at NUM_INPUTS-1→0).
- Locked arbitration: only the locked source lk is eligible. Other sources see ready_out=0 even if valid.
- ready_out[i] = space && grant[i]. At most one bit is set. ready_out must not depend on valid_in of other sources beyond the grant logic.
- Accept: valid_in[g] && ready_out[g]. The beat is written to the buffer tail with sel=g.
- Lock rules:
  - Accepted beat with eop=0: lock<=1, lk<=g.
  - Accepted beat with eop=1: lock<=0 and rr<=(g+1) mod NUM_INPUTS.
  - The rr pointer changes only on an eop accept.
- Single-beat packets (sop=eop=1) never lock.
- A beat with sop=0 arriving from an unlocked source is passed through unchanged. A simulation assertion flags it, with no RTL correction.
- Output:
  - valid_out=(count>0). Outputs show the buffer head.
  - Pop on valid_out && ready_in.
- Simultaneous push and pop: count unchanged, order preserved.
- Latency: a beat accepted in cycle N is visible at the output in cycle N+1 when the buffer was empty.
- Throughput: full rate of 1 beat/cycle while ready_in=1.
- Backpressure: with ready_in=0, two beats are accepted, then all ready_out=0 until a pop. The pop frees space the following cycle (registered count).
- Counters, on each output handshake:
  - retired_threads += popcount(tmask_out).
  - If eop_out=1, retired_instrs += 1.
  - Both counters wrap modulo 2^64.
- Reset mid-packet: lock is cleared and the buffer is flushed. Upstream must also reset, and no partial packet survives.
- NUM_INPUTS=1: arbitration degenerates to grant=valid_in[0], sel_out=0, and the lock logic remains present.

Test Plan:
- Single source, 3 single-beat packets, ready_in=1 → outputs in cycles 1,2,3 with sel_out=0; retired_instrs=3; retired_threads = sum of popcounts, e.g. tmasks 4'hF,4'h3,4'h1 → 7.
- Sources 0..3 all valid with single-beat packets, continuously → grant order 0,1,2,3,0,…; each source receives exactly 1 of every 4 accepts.
- Source 1 sends a 4-beat packet (sop on beat0, eop on beat3) while source 2 is valid → output sel sequence is 1,1,1,1,2; source 2 ready_out=0 for those 4 cycles; rr=2 after eop.
- ready_in=0 for 5 cycles with source 0 valid → exactly 2 beats accepted, ready_out[0]=0 thereafter. Release → output drains in order with no loss or duplication.
- Reset asserted mid-packet (after beat 1 of a 3-beat packet) → next cycle valid_out=0, counters=0, lock=0. A fresh packet from source 3 is then granted immediately.
- Counter wrap: force retired_instrs to 2^64-1, commit one eop beat → retired_instrs=0.
